// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster timing for a VGA output.
// Two 12-bit counters (pixel within line, line within frame) are decoded into
// sync, blanking and frame-start strobes. Every output is a flop loaded from
// the same counter state, so coordinates and strobes change on the same edge.
module vga_timing_gen #(
   parameter int   H_ACTIVE = 1024,
   parameter int   H_FP     = 24,
   parameter int   H_SYNC   = 136,
   parameter int   H_BP     = 160,
   parameter int   V_ACTIVE = 768,
   parameter int   V_FP     = 3,
   parameter int   V_SYNC   = 6,
   parameter int   V_BP     = 29,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        horiz_sync,
   output logic        vert_sync,
   output logic        video_on,
   output logic [11:0] pixel_row,
   output logic [11:0] pixel_column,
   output logic        frame_start
);

   // Line/frame geometry, all in the 12-bit counter domain.
   localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [11:0] H_VIS      = 12'(H_ACTIVE);
   localparam logic [11:0] V_VIS      = 12'(V_ACTIVE);
   localparam logic [11:0] HS_FIRST   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [11:0] VS_FIRST   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_LAST    = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

   // Raster position counters. They run one position ahead of the outputs:
   // the output flops capture the decode of the position the counters hold,
   // so after reset release the first edge presents (0,0).
   logic [11:0] h_cnt_q, h_cnt_d;
   logic [11:0] v_cnt_q, v_cnt_d;

   // Registered outputs.
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        video_on_q, video_on_d;
   logic        frame_start_q, frame_start_d;
   logic [11:0] pixel_row_q, pixel_row_d;
   logic [11:0] pixel_column_q, pixel_column_d;

   // Next raster position: advance the pixel, wrap the line and the frame.
   // The >= compares keep the counters bounded even if they were corrupted.
   always_comb begin
      h_cnt_d = h_cnt_q + 12'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q >= H_LAST) begin
         h_cnt_d = 12'd0;
         if (v_cnt_q >= V_LAST) begin
            v_cnt_d = 12'd0;
         end else begin
            v_cnt_d = v_cnt_q + 12'd1;
         end
      end
   end

   // Decode the current counter position into the values the outputs take next.
   always_comb begin
      pixel_column_d = h_cnt_q;
      pixel_row_d    = v_cnt_q;
      hs_d           = ((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      vs_d           = ((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
      video_on_d     = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      frame_start_d  = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
   end

   // Counter and output registers; reset parks everything at the frame origin
   // with syncs inactive and blanking asserted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt_q        <= 12'd0;
         v_cnt_q        <= 12'd0;
         hs_q           <= ~SYNC_POL;
         vs_q           <= ~SYNC_POL;
         video_on_q     <= 1'b0;
         frame_start_q  <= 1'b0;
         pixel_row_q    <= 12'd0;
         pixel_column_q <= 12'd0;
      end else begin
         h_cnt_q        <= h_cnt_d;
         v_cnt_q        <= v_cnt_d;
         hs_q           <= hs_d;
         vs_q           <= vs_d;
         video_on_q     <= video_on_d;
         frame_start_q  <= frame_start_d;
         pixel_row_q    <= pixel_row_d;
         pixel_column_q <= pixel_column_d;
      end
   end

   assign horiz_sync   = hs_q;
   assign vert_sync    = vs_q;
   assign video_on     = video_on_q;
   assign frame_start  = frame_start_q;
   assign pixel_row    = pixel_row_q;
   assign pixel_column = pixel_column_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks two instances of the timing generator against an
// arithmetic raster model. The default 1024x768 instance is exercised for a few
// dozen lines; a reduced-geometry instance (active-high syncs) is run through
// complete frames, wrap, and an asynchronous mid-frame reset.
module tb_vga_timing_gen;

   // Reduced geometry: 128x128 visible so the 128x128 scaler maps 1:1.
   localparam longint S_HA = 128, S_HF = 4, S_HS = 8, S_HB = 12;
   localparam longint S_VA = 128, S_VF = 2, S_VS = 3, S_VB = 5;
   localparam longint S_HT = S_HA + S_HF + S_HS + S_HB;   // 152
   localparam longint S_VT = S_VA + S_VF + S_VS + S_VB;   // 138
   localparam longint S_FRAME = S_HT * S_VT;              // 20976
   localparam bit     S_POL = 1'b1;

   localparam longint D_HA = 1024, D_HF = 24, D_HS = 136, D_HB = 160;
   localparam longint D_VA = 768,  D_VF = 3,  D_VS = 6,   D_VB = 29;
   localparam longint D_HT = 1344;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        hs_d, vs_d, vo_d, fs_d;
   logic [11:0] row_d, col_d;
   logic        hs_s, vs_s, vo_s, fs_s;
   logic [11:0] row_s, col_s;

   int checks = 0;
   int errors = 0;

   bit     running = 1'b0;
   longint k = 0;           // posedges since reset release

   // Observed-event bookkeeping for the reduced instance.
   longint last_hs_edge, last_fs, vo_tally, vs_tally, d_last_hs_edge, d_vo_line;
   bit     prev_hs_act, d_prev_hs_act, frame_open;

   always #5 clk = ~clk;

   vga_timing_gen dut_def (
      .clock(clk), .reset_n(rst_n),
      .horiz_sync(hs_d), .vert_sync(vs_d), .video_on(vo_d),
      .pixel_row(row_d), .pixel_column(col_d), .frame_start(fs_d)
   );

   vga_timing_gen #(
      .H_ACTIVE(128), .H_FP(4), .H_SYNC(8), .H_BP(12),
      .V_ACTIVE(128), .V_FP(2), .V_SYNC(3), .V_BP(5),
      .SYNC_POL(1'b1)
   ) dut_sml (
      .clock(clk), .reset_n(rst_n),
      .horiz_sync(hs_s), .vert_sync(vs_s), .video_on(vo_s),
      .pixel_row(row_s), .pixel_column(col_s), .frame_start(fs_s)
   );

   // Expected {hsync, vsync, video_on, frame_start, row, column} from the raster rules.
   function automatic logic [27:0] model(longint ha, longint hf, longint hs, longint hb,
                                         longint va, longint vf, longint vs, longint vb,
                                         bit pol, bit run, longint kk);
      longint ht, vt, pos, row, col;
      bit h, v, vo, fs;
      if (!run) return {~pol, ~pol, 1'b0, 1'b0, 12'd0, 12'd0};
      ht  = ha + hf + hs + hb;
      vt  = va + vf + vs + vb;
      pos = (kk - 1) % (ht * vt);
      row = pos / ht;
      col = pos % ht;
      h   = (col >= ha + hf && col < ha + hf + hs) ? pol : ~pol;
      v   = (row >= va + vf && row < va + vf + vs) ? pol : ~pol;
      vo  = (col < ha) && (row < va);
      fs  = (pos == 0);
      return {h, v, vo, fs, 12'(row), 12'(col)};
   endfunction

   // 128x128 world address from screen coordinates.
   function automatic longint scaler_addr(longint row, longint col, longint va, longint ha);
      return ((row * 128) / va) * 128 + (col * 128) / ha;
   endfunction

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
      if (errors >= 100) begin
         $display("FAIL aborting after %0d errors", errors);
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   endtask

   task automatic clear_events();
      last_hs_edge   = -1;
      last_fs        = -1;
      d_last_hs_edge = -1;
      vo_tally       = 0;
      vs_tally       = 0;
      d_vo_line      = 0;
      frame_open     = 1'b0;
      prev_hs_act    = 1'b0;
      d_prev_hs_act  = 1'b0;
   endtask

   // Per-position comparison of both instances plus interval bookkeeping.
   task automatic check_all();
      logic [27:0] es, ed;
      longint pos;
      bit hs_act, d_hs_act;
      es = model(S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_POL, running, k);
      ed = model(D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB, 1'b0, running, k);
      check("small_outputs",   longint'({hs_s, vs_s, vo_s, fs_s, row_s, col_s}), longint'(es));
      check("default_outputs", longint'({hs_d, vs_d, vo_d, fs_d, row_d, col_d}), longint'(ed));
      if (!running) return;
      pos = (k - 1) % S_FRAME;

      // Reduced instance: hsync period, frame period and per-frame tallies.
      hs_act = (hs_s == S_POL);
      if (hs_act && !prev_hs_act) begin
         if (last_hs_edge >= 0) check("small_hsync_period", k - last_hs_edge, S_HT);
         check("small_hsync_start_col", longint'(col_s), S_HA + S_HF);
         last_hs_edge = k;
      end
      if (!hs_act && prev_hs_act) check("small_hsync_end_col", longint'(col_s), S_HA + S_HF + S_HS);
      prev_hs_act = hs_act;
      if (fs_s) begin
         if (last_fs >= 0) check("frame_start_period", k - last_fs, S_FRAME);
         if (frame_open) begin
            check("frame_video_on_count", vo_tally, S_HA * S_VA);
            check("frame_vsync_count", vs_tally, S_VS * S_HT);
         end
         last_fs    = k;
         frame_open = 1'b1;
         vo_tally   = 0;
         vs_tally   = 0;
      end
      if (vo_s) vo_tally++;
      if (vs_s == S_POL) vs_tally++;

      // Scaler corner addresses.
      if (pos == S_VA * S_HT + S_HA - 1 - S_HT) begin
         check("scaler_corner_addr", scaler_addr(longint'(row_s), longint'(col_s), S_VA, S_HA), 16383);
         check("scaler_corner_vo", longint'(vo_s), 1);
      end
      if (pos == 0) begin
         check("scaler_origin_addr", scaler_addr(longint'(row_s), longint'(col_s), S_VA, S_HA), 0);
         check("scaler_origin_vo", longint'(vo_s), 1);
      end

      // Default instance: hsync falling edge spacing and visible pixels per line.
      d_hs_act = (hs_d == 1'b0);
      if (d_hs_act && !d_prev_hs_act) begin
         if (d_last_hs_edge >= 0) check("default_hsync_period", k - d_last_hs_edge, D_HT);
         check("default_hsync_fall_col", longint'(col_d), 1048);
         check("default_line_video_on", d_vo_line, 1024);
         d_last_hs_edge = k;
         d_vo_line      = 0;
      end
      if (!d_hs_act && d_prev_hs_act) check("default_hsync_rise_col", longint'(col_d), 1184);
      d_prev_hs_act = d_hs_act;
      if (vo_d) d_vo_line++;
   endtask

   task automatic step();
      @(posedge clk);
      if (running) k++;
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int hold;
      longint target;
      clear_events();

      // Reset held for at least 10 clocks.
      hold = 10 + int'($urandom_range(0, 5));
      for (int i = 0; i < hold; i++) step();

      // Release between edges; the next edge must present (0,0).
      rst_n   = 1'b1;
      running = 1'b1;
      k       = 0;
      step();
      check("release_frame_start", longint'(fs_s), 1);
      check("release_video_on", longint'(vo_d), 1);

      // Two full reduced frames plus a random tail: covers wrap at (last row, last col).
      target = 2 * S_FRAME + longint'($urandom_range(50, 400));
      while (k < target) step();

      // Asynchronous reset a random distance into a frame, mid-cycle.
      target = k + S_FRAME / 2 + longint'($urandom_range(0, 2000));
      while (k < target) step();
      @(posedge clk);
      #(1 + int'($urandom_range(0, 2)));
      rst_n   = 1'b0;
      running = 1'b0;
      #1;
      check_all();
      clear_events();
      hold = 3 + int'($urandom_range(0, 4));
      for (int i = 0; i < hold; i++) step();

      // Restart: frame begins again at the origin.
      rst_n   = 1'b1;
      running = 1'b1;
      k       = 0;
      step();
      check("restart_frame_start", longint'(fs_s), 1);
      while (k < 3 * S_HT) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
